// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stage stall/flush, memory-wait FSM and perf counters.
// In: D/E/M/W register ids, write enables, load_e, pc_src_e, mem_req_m, mem_ready.
// Out: forward_a_e/forward_b_e, stall_f..stall_w, flush_d/flush_e, mem_timeout, stall_count/flush_count.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_e,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic                      load_e,
  input  logic                      pc_src_e,
  input  logic                      mem_req_m,
  input  logic                      mem_ready,
  output logic [1:0]                forward_a_e,
  output logic [1:0]                forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      stall_e,
  output logic                      stall_m,
  output logic                      stall_w,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          freeze;
  logic          lu;

  assign freeze = mem_req_m && !mem_ready;
  assign lu = load_e && (rd_e != '0) &&
              ((rd_e == rs1_d) || (rd_e == rs2_d));

  // M result is younger than W, so it wins.
  always_comb begin
    forward_a_e = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
      forward_a_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
      forward_a_e = 2'b01;
  end

  always_comb begin
    forward_b_e = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
      forward_b_e = 2'b10;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
      forward_b_e = 2'b01;
  end

  // A memory wait freezes everything, so a pending
  // redirect or bubble is held until the access ends.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    priority case (1'b1)
      freeze: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        stall_w = 1'b1;
      end
      pc_src_e: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      lu: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (freeze) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (!freeze) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WMAX) begin
            wait_cnt <= wait_cnt + WW'(1);
            if (wait_cnt == WLAST) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (flush_e && (flush_count != '1))
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with a per-cycle reference model.
// Small counter width and timeout so saturation and timeout are reachable.
module tb_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RW-1:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
  logic [RW-1:0] rd_e = '0, rd_m = '0, rd_w = '0;
  logic reg_write_m = 0, reg_write_w = 0, load_e = 0;
  logic pc_src_e = 0, mem_req_m = 0, mem_ready = 0;
  logic [1:0] forward_a_e, forward_b_e;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int passed = 0;
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_to = 0;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .load_e(load_e), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {stall_f,stall_d,stall_e,stall_m,stall_w,flush_d,flush_e}
  function automatic logic [6:0] ctl();
    if (mem_req_m && !mem_ready) return 7'b11111_00;
    if (pc_src_e) return 7'b00000_11;
    if (load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d))
      return 7'b11000_01;
    return 7'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      passed++;
  endtask

  // Model: the wait state is simply "freeze was seen at the previous
  // edge", so wait edges = consecutive freeze edges minus one.
  always @(negedge rst_n) begin
    m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
  end

  always @(posedge clk) begin
    logic [6:0] c;
    if (rst_n) begin
      c = ctl();
      if (c[6] && m_stall < CMAX) m_stall++;
      if (c[0] && m_flush < CMAX) m_flush++;
      if (mem_req_m && !mem_ready) begin
        m_run++;
        if (m_run >= TO + 1) m_to = 1;
      end else begin
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("fwd_a", 32'(forward_a_e), 32'(fwd(rs1_e)));
    chk("fwd_b", 32'(forward_b_e), 32'(fwd(rs2_e)));
    chk("ctrl", 32'({stall_f, stall_d, stall_e, stall_m, stall_w,
                     flush_d, flush_e}), 32'(ctl()));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
  end

  task automatic clr();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    reg_write_m = 0; reg_write_w = 0; load_e = 0;
    pc_src_e = 0; mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("rst_stall_cnt", 32'(stall_count), 0);
    chk("rst_flush_cnt", 32'(flush_count), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    rs1_e = 5; rd_m = 5; reg_write_m = 1; #1;
    chk("rst_fwd_live", 32'(forward_a_e), 32'b10);
    clr();
    #10 rst_n = 1;

    edge1();
    rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; #1;
    chk("fwd_m", 32'(forward_a_e), 32'b10);
    reg_write_m = 0; #1;
    chk("fwd_w", 32'(forward_a_e), 32'b01);
    reg_write_m = 1; rd_m = 0; rd_w = 0; #1;
    chk("fwd_x0", 32'(forward_a_e), 32'b00);
    rs2_e = 3; rd_w = 3; rd_m = 4; #1;
    chk("fwd_b_w", 32'(forward_b_e), 32'b01);
    clr();

    edge1();
    load_e = 1; rd_e = 7; rs2_d = 7; #1;
    chk("lu_ctrl", 32'({stall_f, stall_d, flush_e, flush_d}), 32'b1110);
    repeat (3) @(posedge clk); #1;
    chk("lu_stall_cnt", 32'(stall_count), 3);
    pc_src_e = 1; #1;
    chk("br_ctrl", 32'({stall_f, stall_d, flush_e, flush_d}), 32'b0011);
    edge1();
    chk("br_flush_cnt", 32'(flush_count), 4);
    clr();

    edge1();
    mem_req_m = 1; pc_src_e = 1; #1;
    chk("frz_ctrl", 32'({stall_f, stall_d, stall_e, stall_m, stall_w,
                         flush_d, flush_e}), 32'b1111100);
    repeat (3) @(posedge clk); #1;
    mem_ready = 1; #1;
    chk("rel_flush", 32'({flush_d, flush_e, stall_e}), 32'b110);
    edge1();
    chk("rel_stall_cnt", 32'(stall_count), 6);
    chk("rel_flush_cnt", 32'(flush_count), 5);
    chk("rel_no_to", 32'(mem_timeout), 0);
    clr();

    edge1();
    mem_req_m = 1;
    repeat (4) @(posedge clk); #1;
    chk("to_before", 32'(mem_timeout), 0);
    edge1();
    chk("to_after", 32'(mem_timeout), 1);
    edge1();
    clr();
    edge1();
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_stall_cnt", 32'(stall_count), 12);

    load_e = 1; rd_e = 9; rs1_d = 9;
    repeat (10) @(posedge clk); #1;
    chk("sat_stall", 32'(stall_count), CMAX);
    chk("sat_flush", 32'(flush_count), CMAX);
    clr();

    edge1();
    mem_req_m = 1;
    repeat (2) @(posedge clk); #2;
    rst_n = 0; #1;
    chk("arst_stall_cnt", 32'(stall_count), 0);
    chk("arst_flush_cnt", 32'(flush_count), 0);
    chk("arst_timeout", 32'(mem_timeout), 0);
    chk("arst_stall_live", 32'(stall_w), 1);
    #3 rst_n = 1;
    repeat (4) @(posedge clk); #1;
    chk("rerun_before", 32'(mem_timeout), 0);
    edge1();
    chk("rerun_after", 32'(mem_timeout), 1);
    clr();
    edge1();
    edge1();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
